power_alu: RTL and testbench
============================

# power_alu

8-bit multi-cycle ALU with an internal accumulator. It executes one operation per `alu_en` pulse from the instruction-decode controller and returns a one-cycle `alu_done`. Single-cycle ops finish in 1 cycle. Multiply, divide and modulo run iteratively over 8 cycles. This block is the execution stage directly downstream of the controller, which holds `a`/`b`/`op`/`acc` stable until `alu_done`.

## Interface
- `WIDTH`, 8: operand/accumulator width; the only supported value is 8. The shift amount is taken from `b[2:0]`.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-low reset. Asserting it (low) immediately forces the reset values listed below.
- `a` input 8: operand A.
- `b` input 8: operand B.
- `op` input 4: opcode.
- `acc` input 1: 1 = use the accumulator in place of `a` as operand A.
- `alu_en` input 1: start request. Sampled only in IDLE.
- `alu_done` output 1: one-cycle completion pulse. Reset 0.
- `result` output 16: registered result. `[15:8]` is nonzero only for MUL. Reset 0.
- `acc_out` output 8: accumulator value. Reset 0.
- `flag_z`, `flag_c`, `flag_v`, `flag_n`, `flag_dz` output 1 each: registered flags. All reset 0.

## Operation
- Opcodes:
  - 0 ADD, 1 SUB (A−B), 2 AND, 3 OR, 4 XOR, 5 NAND, 6 NOR, 7 XNOR.
  - 8 NOT A, 9 SHL, 10 SHR (logical), 11 ROL, 12 ROR.
  - 13 MUL (unsigned 8×8→16), 14 DIV (unsigned quotient), 15 MOD (unsigned remainder).
- Operand A is `acc ? acc_q : a`, latched at the start edge. B and `op` are also latched at the start edge. Inputs are ignored after that edge.
- States:
  - IDLE: `alu_en`=1 → latch operands. DIV/MOD with B=0 → DONE. Ops 13–15 otherwise → EXEC with count=0. All other ops → DONE.
  - EXEC: one shift-add (MUL) or restoring-divide (DIV/MOD) step per cycle. Count increments each step; after the step at count=7 → DONE.
  - DONE: register `result` and the flags, write `result[7:0]` to the accumulator, pulse `alu_done`, then → IDLE.
- Flags:
  - `flag_z`: result==0 over all 16 bits.
  - `flag_n`: `result[7]`.
  - `flag_v`: signed overflow for ADD/SUB; otherwise 0.
  - `flag_c`:
    - ADD: carry out.
    - SUB: borrow (A<B).
    - SHL/SHR/ROL/ROR: last bit shifted out, or 0 when the shift amount is 0.
    - MUL: `result[15:8]`≠0.
    - All other ops: 0.
  - `flag_dz`: 1 only for DIV/MOD with B=0; otherwise 0.
- Divide by zero: DIV gives 0x00FF and MOD gives 0x00 & A, both with `flag_dz`=1. No iterations are run.
- Results of 8-bit ops are zero-extended to 16 bits.

## Timing
- Start edge E0: `alu_en`=1 is sampled in IDLE.
- Single-cycle ops and divide-by-zero: `alu_done`=1 in the cycle after E1. `result`, the flags and `acc_out` become valid at E1.
- MUL/DIV/MOD: EXEC steps occur at E1..E8. `alu_done`, `result`, the flags and `acc_out` update at E9.
- `alu_done` is high for exactly one cycle. `result`, the flags and `acc_out` hold until the next completion.
- `alu_en` during EXEC or DONE is ignored, with no queuing. The earliest next start is the edge after `alu_done` rises.
- `alu_en` held high continuously restarts on every IDLE edge, using the operands present at that edge.
- Reset asserted mid-operation: state→IDLE, count=0, accumulator=0, all outputs at reset values, no `alu_done`. The operation is lost.

## Structure
- Package `power_alu_pkg`: opcode constants (`OP_ADD`..`OP_MOD`), state encoding (IDLE/EXEC/DONE), and `WIDTH`.
- Sub-module `alu_muldiv_seq`:
  - iterative 8-step multiplier/divider with `start`, `is_div`, operands, `busy`, and 16-bit product / quotient+remainder outputs;
  - the top level sequences it from EXEC.
- Combinational ops and flag logic live in the top level.

## Test plan
- Reset, then `a`=0x30, `b`=0x1D, ADD → `alu_done` 1 cycle after start; `result`=0x004D; `acc_out`=0x4D; `flag_z`=`flag_c`=`flag_v`=0.
- Accumulate: after the first case, `acc`=1, `b`=0x1D, ADD → `result`=0x006A; `acc_out`=0x6A.
- MUL 0x30×0x1D → `alu_done` exactly 9 cycles after start; `result`=0x0570; `flag_c`=1; `alu_en` pulsed mid-EXEC is ignored.
- DIV/MOD 0x30,0x1D → 0x0001, then 0x0013. DIV with B=0 → 0x00FF, `flag_dz`=1, done after 1 cycle.
- ADD 0x7F+0x01 → 0x0080 with `flag_v`=1, `flag_n`=1. SUB 0x00−0x01 → 0x00FF with `flag_c`=1.
- Assert `rst` low during MUL EXEC cycle 4 → all outputs 0 immediately, no `alu_done`. A new ADD after release completes normally.

Source files
------------

// File: rtl/power_alu_pkg.sv
// Shared definitions for the power_alu execution stage: operand width,
// opcode values and the controller state encoding.
package power_alu_pkg;

   localparam int WIDTH = 8;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_NAND = 4'd5,
      OP_NOR  = 4'd6,
      OP_XNOR = 4'd7,
      OP_NOT  = 4'd8,
      OP_SHL  = 4'd9,
      OP_SHR  = 4'd10,
      OP_ROL  = 4'd11,
      OP_ROR  = 4'd12,
      OP_MUL  = 4'd13,
      OP_DIV  = 4'd14,
      OP_MOD  = 4'd15
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_e;

   // True for the opcodes that run through the iterative multiplier/divider.
   function automatic logic is_iterative(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
   endfunction

endpackage

// File: rtl/power_alu_muldiv_seq.sv
// Iterative 8-step unsigned engine: shift-add multiply or restoring divide.
// Operands are captured on i_start; one step runs per cycle while busy, and
// the outputs are final once busy drops after the eighth step.
module alu_muldiv_seq
   import power_alu_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_start,
   input  logic               i_is_div,
   input  logic [WIDTH-1:0]   i_a,
   input  logic [WIDTH-1:0]   i_b,
   output logic               o_busy,
   output logic [2*WIDTH-1:0] o_product,
   output logic [WIDTH-1:0]   o_quot,
   output logic [WIDTH-1:0]   o_rem
);

   logic               r_busy;
   logic               r_is_div;
   logic [2:0]         r_cnt;
   logic [WIDTH-1:0]   r_oper;      // multiplicand (MUL) or divisor (DIV/MOD)
   logic [2*WIDTH-1:0] r_prod;      // upper half accumulates, lower half shifts out multiplier
   logic [WIDTH-1:0]   r_quot;      // dividend shifts out the top, quotient bits enter the bottom
   logic [WIDTH-1:0]   r_rem;

   logic [WIDTH:0]     w_add;
   logic [WIDTH:0]     w_shift;
   logic [WIDTH:0]     w_trial;
   logic               w_fits;

   // Multiply step: add multiplicand into the upper half when the current multiplier bit is set.
   assign w_add   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_oper} : '0);
   // Divide step: bring down the next dividend bit and try to subtract the divisor.
   assign w_shift = {r_rem, r_quot[WIDTH-1]};
   assign w_trial = w_shift - {1'b0, r_oper};
   assign w_fits  = (w_shift >= {1'b0, r_oper});

   // Capture operands on start, then run one multiply or divide step per cycle for 8 cycles.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_busy   <= 1'b0;
         r_is_div <= 1'b0;
         r_cnt    <= '0;
         r_oper   <= '0;
         r_prod   <= '0;
         r_quot   <= '0;
         r_rem    <= '0;
      end else if (i_start) begin
         r_busy   <= 1'b1;
         r_is_div <= i_is_div;
         r_cnt    <= '0;
         if (i_is_div) begin
            r_oper <= i_b;
            r_quot <= i_a;
            r_rem  <= '0;
         end else begin
            r_oper <= i_a;
            r_prod <= {{WIDTH{1'b0}}, i_b};
         end
      end else if (r_busy) begin
         if (r_is_div) begin
            r_quot <= {r_quot[WIDTH-2:0], w_fits};
            r_rem  <= w_fits ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
         end else begin
            r_prod <= {w_add, r_prod[WIDTH-1:1]};
         end
         r_cnt <= r_cnt + 3'd1;
         if (r_cnt == 3'd7) begin
            r_busy <= 1'b0;
         end
      end
   end

   assign o_busy    = r_busy;
   assign o_product = r_prod;
   assign o_quot    = r_quot;
   assign o_rem     = r_rem;

endmodule

// File: rtl/power_alu.sv
// 8-bit execution-stage ALU with accumulator. Single-cycle ops complete
// one cycle after the start edge; MUL/DIV/MOD run 8 iterative steps first.
// Handshake: alu_en is sampled only in IDLE; the controller keeps inputs
// stable until alu_done, which pulses for exactly one cycle per operation.
module power_alu
   import power_alu_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [3:0]         op,
   input  logic               acc,
   input  logic               alu_en,
   output logic               alu_done,
   output logic [2*WIDTH-1:0] result,
   output logic [WIDTH-1:0]   acc_out,
   output logic               flag_z,
   output logic               flag_c,
   output logic               flag_v,
   output logic               flag_n,
   output logic               flag_dz,
   output state_e             o_state_dbg
);

   state_e             r_state;
   logic [2:0]         r_count;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   op_e                r_op;
   logic [WIDTH-1:0]   r_acc;
   logic [2*WIDTH-1:0] r_result;
   logic               r_done;
   logic               r_z;
   logic               r_c;
   logic               r_v;
   logic               r_n;
   logic               r_dz;

   logic [WIDTH-1:0]   w_opa;
   logic               w_div_zero;
   logic               w_start_seq;
   logic               w_busy;
   logic [2*WIDTH-1:0] w_product;
   logic [WIDTH-1:0]   w_quot;
   logic [WIDTH-1:0]   w_rem;
   logic [WIDTH:0]     w_sum;
   logic [WIDTH:0]     w_diff;
   logic [2*WIDTH-1:0] w_shl;
   logic [2*WIDTH-1:0] w_shr;
   logic               w_sh_nz;
   logic [2*WIDTH-1:0] w_res;
   logic               w_c;
   logic               w_v;
   logic               w_dz;

   assign w_opa       = acc ? r_acc : a;
   assign w_div_zero  = ((op == OP_DIV) || (op == OP_MOD)) && (b == '0);
   assign w_start_seq = (r_state == IDLE) && alu_en && is_iterative(op) && !w_div_zero;

   alu_muldiv_seq u_seq (
      .i_clk     (clk),
      .i_rst_n   (rst),
      .i_start   (w_start_seq),
      .i_is_div  (op != OP_MUL),
      .i_a       (w_opa),
      .i_b       (b),
      .o_busy    (w_busy),
      .o_product (w_product),
      .o_quot    (w_quot),
      .o_rem     (w_rem)
   );

   // Both shifts are done in a double-width window so the bits pushed out land next to the result.
   assign w_sum   = {1'b0, r_a} + {1'b0, r_b};
   assign w_diff  = {1'b0, r_a} - {1'b0, r_b};
   assign w_shl   = {{WIDTH{1'b0}}, r_a} << r_b[2:0];
   assign w_shr   = {r_a, {WIDTH{1'b0}}} >> r_b[2:0];
   assign w_sh_nz = (r_b[2:0] != 3'd0);

   // Result and carry/overflow/divide-by-zero for the latched operation.
   always_comb begin
      w_res = '0;
      w_c   = 1'b0;
      w_v   = 1'b0;
      w_dz  = 1'b0;
      case (r_op)
         OP_ADD: begin
            w_res = {{WIDTH{1'b0}}, w_sum[WIDTH-1:0]};
            w_c   = w_sum[WIDTH];
            w_v   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
         end
         OP_SUB: begin
            w_res = {{WIDTH{1'b0}}, w_diff[WIDTH-1:0]};
            w_c   = w_diff[WIDTH];
            w_v   = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_a[WIDTH-1]);
         end
         OP_AND:  w_res = {{WIDTH{1'b0}}, r_a & r_b};
         OP_OR:   w_res = {{WIDTH{1'b0}}, r_a | r_b};
         OP_XOR:  w_res = {{WIDTH{1'b0}}, r_a ^ r_b};
         OP_NAND: w_res = {{WIDTH{1'b0}}, ~(r_a & r_b)};
         OP_NOR:  w_res = {{WIDTH{1'b0}}, ~(r_a | r_b)};
         OP_XNOR: w_res = {{WIDTH{1'b0}}, ~(r_a ^ r_b)};
         OP_NOT:  w_res = {{WIDTH{1'b0}}, ~r_a};
         OP_SHL: begin
            w_res = {{WIDTH{1'b0}}, w_shl[WIDTH-1:0]};
            w_c   = w_sh_nz & w_shl[WIDTH];
         end
         OP_SHR: begin
            w_res = {{WIDTH{1'b0}}, w_shr[2*WIDTH-1:WIDTH]};
            w_c   = w_sh_nz & w_shr[WIDTH-1];
         end
         OP_ROL: begin
            w_res = {{WIDTH{1'b0}}, w_shl[WIDTH-1:0] | w_shl[2*WIDTH-1:WIDTH]};
            w_c   = w_sh_nz & w_shl[WIDTH];
         end
         OP_ROR: begin
            w_res = {{WIDTH{1'b0}}, w_shr[2*WIDTH-1:WIDTH] | w_shr[WIDTH-1:0]};
            w_c   = w_sh_nz & w_shr[WIDTH-1];
         end
         OP_MUL: begin
            w_res = w_product;
            w_c   = (w_product[2*WIDTH-1:WIDTH] != '0);
         end
         OP_DIV: begin
            w_dz  = (r_b == '0);
            w_res = w_dz ? {{WIDTH{1'b0}}, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, w_quot};
         end
         OP_MOD: begin
            w_dz  = (r_b == '0);
            w_res = w_dz ? {{WIDTH{1'b0}}, r_a} : {{WIDTH{1'b0}}, w_rem};
         end
         default: w_res = '0;
      endcase
   end

   // Controller FSM: latch on start, sequence the iterative engine, register results on DONE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= IDLE;
         r_count  <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_op     <= OP_ADD;
         r_acc    <= '0;
         r_result <= '0;
         r_done   <= 1'b0;
         r_z      <= 1'b0;
         r_c      <= 1'b0;
         r_v      <= 1'b0;
         r_n      <= 1'b0;
         r_dz     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (alu_en) begin
                  r_a     <= w_opa;
                  r_b     <= b;
                  r_op    <= op_e'(op);
                  r_count <= '0;
                  r_state <= (is_iterative(op) && !w_div_zero) ? EXEC : DONE;
               end
            end
            EXEC: begin
               if (w_busy) begin
                  r_count <= r_count + 3'd1;
               end
               if (r_count == 3'd7) begin
                  r_state <= DONE;
               end
            end
            DONE: begin
               r_result <= w_res;
               r_acc    <= w_res[WIDTH-1:0];
               r_z      <= (w_res == '0);
               r_n      <= w_res[WIDTH-1];
               r_c      <= w_c;
               r_v      <= w_v;
               r_dz     <= w_dz;
               r_done   <= 1'b1;
               r_state  <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign alu_done    = r_done;
   assign result      = r_result;
   assign acc_out     = r_acc;
   assign flag_z      = r_z;
   assign flag_c      = r_c;
   assign flag_v      = r_v;
   assign flag_n      = r_n;
   assign flag_dz     = r_dz;
   assign o_state_dbg = r_state;

endmodule

// File: tb/tb_power_alu.sv
// Directed and randomized checks of power_alu against an arithmetic reference model.
module tb_power_alu;
   import power_alu_pkg::*;

   logic         clk;
   logic         rst;
   logic [7:0]   a;
   logic [7:0]   b;
   logic [3:0]   op;
   logic         acc;
   logic         alu_en;
   logic         alu_done;
   logic [15:0]  result;
   logic [7:0]   acc_out;
   logic         flag_z, flag_c, flag_v, flag_n, flag_dz;
   state_e       state_dbg;

   int n_checks = 0;
   int n_pass   = 0;
   logic [7:0] m_acc = 8'h00;

   power_alu dut (
      .clk         (clk),
      .rst         (rst),
      .a           (a),
      .b           (b),
      .op          (op),
      .acc         (acc),
      .alu_en      (alu_en),
      .alu_done    (alu_done),
      .result      (result),
      .acc_out     (acc_out),
      .flag_z      (flag_z),
      .flag_c      (flag_c),
      .flag_v      (flag_v),
      .flag_n      (flag_n),
      .flag_dz     (flag_dz),
      .o_state_dbg (state_dbg)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [4:0] dut_flags();
      return {flag_z, flag_c, flag_v, flag_n, flag_dz};
   endfunction

   // Reference model: returns {result[15:0], z, c, v, n, dz}.
   function automatic logic [20:0] ref_op(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
      int ia, ib, sa, sb, r, sr, sh;
      logic c, v, dz;
      ia = x; ib = y; sa = $signed(x); sb = $signed(y);
      sh = ib % 8;
      c = 0; v = 0; dz = 0; r = 0;
      case (o)
         4'd0: begin r = ia + ib; c = (r > 255); r = r & 255; sr = sa + sb; v = (sr > 127) || (sr < -128); end
         4'd1: begin r = (ia - ib) & 255; c = (ia < ib); sr = sa - sb; v = (sr > 127) || (sr < -128); end
         4'd2: r = ia & ib;
         4'd3: r = ia | ib;
         4'd4: r = ia ^ ib;
         4'd5: r = ~(ia & ib) & 255;
         4'd6: r = ~(ia | ib) & 255;
         4'd7: r = ~(ia ^ ib) & 255;
         4'd8: r = ~ia & 255;
         4'd9: begin r = (ia << sh) & 255; c = (sh != 0) && (((ia >> (8 - sh)) & 1) == 1); end
         4'd10: begin r = ia >> sh; c = (sh != 0) && (((ia >> (sh - 1)) & 1) == 1); end
         4'd11: begin r = ((ia << sh) | (ia >> (8 - sh))) & 255; c = (sh != 0) && ((r & 1) == 1); end
         4'd12: begin r = ((ia >> sh) | (ia << (8 - sh))) & 255; c = (sh != 0) && (((r >> 7) & 1) == 1); end
         4'd13: begin r = ia * ib; c = (r > 255); end
         4'd14: begin if (ib == 0) begin r = 255; dz = 1; end else r = ia / ib; end
         default: begin if (ib == 0) begin r = ia; dz = 1; end else r = ia % ib; end
      endcase
      return {r[15:0], (r == 0), c, v, ((r >> 7) & 1) == 1, dz};
   endfunction

   // Driver: issue one operation, optionally poke alu_en mid-EXEC, and check everything on completion.
   task automatic run_op(input string tag, input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                         input logic use_acc, input logic poke);
      logic [7:0]  opa;
      logic [20:0] exp;
      int          exp_lat, lat;
      opa     = use_acc ? m_acc : x;
      exp     = ref_op(o, opa, y);
      exp_lat = (o >= 4'd13 && !(o >= 4'd14 && y == 8'h00)) ? 9 : 1;
      op = o; a = x; b = y; acc = use_acc; alu_en = 1'b1;
      @(posedge clk); #1;
      alu_en = 1'b0;
      a = 8'($urandom); b = 8'($urandom); op = 4'($urandom); acc = 1'($urandom);
      lat = 0;
      do begin
         alu_en = poke && (lat == 3);
         @(posedge clk); #1;
         lat++;
      end while (!alu_done && lat < 20);
      alu_en = 1'b0;
      check({tag, ".latency"}, 16'(lat), 16'(exp_lat));
      check({tag, ".result"}, result, exp[20:5]);
      check({tag, ".flags"}, {11'b0, dut_flags()}, {11'b0, exp[4:0]});
      check({tag, ".acc_out"}, {8'h00, acc_out}, {8'h00, exp[12:5]});
      m_acc = exp[12:5];
      @(posedge clk); #1;
      check({tag, ".done_pulse"}, {15'b0, alu_done}, 16'h0000);
   endtask

   initial begin
      int spurious;
      logic [3:0] ro;
      logic [7:0] ra, rb;
      rst = 1'b0; a = 8'h00; b = 8'h00; op = 4'h0; acc = 1'b0; alu_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset.result", result, 16'h0000);
      check("reset.acc", {8'h00, acc_out}, 16'h0000);
      check("reset.flags_done", {10'b0, alu_done, dut_flags()}, 16'h0000);
      check("reset.state", {14'b0, state_dbg}, {14'b0, IDLE});
      rst = 1'b1;
      @(posedge clk); #1;

      run_op("add", 4'd0, 8'h30, 8'h1D, 1'b0, 1'b0);
      run_op("add_acc", 4'd0, 8'hEE, 8'h1D, 1'b1, 1'b0);
      run_op("mul_poke", 4'd13, 8'h30, 8'h1D, 1'b0, 1'b1);
      spurious = 0;
      repeat (4) begin @(posedge clk); #1; if (alu_done) spurious++; end
      check("mul_poke.no_extra_done", 16'(spurious), 16'h0000);
      run_op("div", 4'd14, 8'h30, 8'h1D, 1'b0, 1'b0);
      run_op("mod", 4'd15, 8'h30, 8'h1D, 1'b0, 1'b0);
      run_op("div_zero", 4'd14, 8'h30, 8'h00, 1'b0, 1'b0);
      run_op("mod_zero", 4'd15, 8'hA7, 8'h00, 1'b0, 1'b0);
      run_op("add_ovf", 4'd0, 8'h7F, 8'h01, 1'b0, 1'b0);
      run_op("sub_borrow", 4'd1, 8'h00, 8'h01, 1'b0, 1'b0);
      run_op("shl_zero_amt", 4'd9, 8'h81, 8'h08, 1'b0, 1'b0);
      run_op("ror3", 4'd12, 8'h05, 8'h03, 1'b0, 1'b0);
      run_op("mul_max", 4'd13, 8'hFF, 8'hFF, 1'b0, 1'b0);

      // Reset asserted partway through a multiply.
      op = 4'd13; a = 8'h30; b = 8'h1D; acc = 1'b0; alu_en = 1'b1;
      @(posedge clk); #1;
      alu_en = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("midrst.result", result, 16'h0000);
      check("midrst.acc", {8'h00, acc_out}, 16'h0000);
      check("midrst.flags_done", {10'b0, alu_done, dut_flags()}, 16'h0000);
      @(posedge clk); #3;
      rst = 1'b1;
      m_acc = 8'h00;
      spurious = 0;
      repeat (10) begin @(posedge clk); #1; if (alu_done) spurious++; end
      check("midrst.no_done", 16'(spurious), 16'h0000);
      run_op("post_rst_add", 4'd0, 8'h11, 8'h22, 1'b1, 1'b0);

      // Randomized operations against the reference model.
      for (int i = 0; i < 40; i++) begin
         ro = 4'($urandom_range(0, 15));
         ra = 8'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
